// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: exception cause codes as carried on the trap path.
package riscv_pkg;

  typedef logic [4:0] xcpt_code_t;

  localparam xcpt_code_t XCPT_INSTR_MISALIGNED = 5'd0;
  localparam xcpt_code_t XCPT_ILLEGAL_INSTR    = 5'd2;
  localparam xcpt_code_t XCPT_LOAD_MISALIGNED  = 5'd4;
  localparam xcpt_code_t XCPT_LOAD_FAULT       = 5'd5;

endpackage

// File: rtl/tartaruga_pkg.sv
// Core-level types for the trap controller: FSM state encoding and default trap vector.
package tartaruga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } trap_state_t;

  localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;
  localparam int unsigned DRAIN_CNT_W         = 4;

endpackage

// File: rtl/trap_prio_sel.sv
// Combinational exception arbiter: memory beats execute beats decode (oldest instruction wins).
module trap_prio_sel
  import riscv_pkg::*;
(
  input  logic        dec_valid_i,
  input  xcpt_code_t  dec_code_i,
  input  logic [31:0] dec_pc_i,
  input  logic [31:0] dec_value_i,
  input  logic        exe_valid_i,
  input  xcpt_code_t  exe_code_i,
  input  logic [31:0] exe_pc_i,
  input  logic [31:0] exe_value_i,
  input  logic        mem_valid_i,
  input  xcpt_code_t  mem_code_i,
  input  logic [31:0] mem_pc_i,
  input  logic [31:0] mem_value_i,
  output logic        sel_valid_o,
  output xcpt_code_t  sel_code_o,
  output logic [31:0] sel_pc_o,
  output logic [31:0] sel_value_o
);

  // Later assignments override earlier ones, so the oldest stage is written last.
  always_comb begin
    sel_valid_o = 1'b0;
    sel_code_o  = '0;
    sel_pc_o    = '0;
    sel_value_o = '0;
    if (dec_valid_i) begin
      sel_valid_o = 1'b1;
      sel_code_o  = dec_code_i;
      sel_pc_o    = dec_pc_i;
      sel_value_o = dec_value_i;
    end
    if (exe_valid_i) begin
      sel_valid_o = 1'b1;
      sel_code_o  = exe_code_i;
      sel_pc_o    = exe_pc_i;
      sel_value_o = exe_value_i;
    end
    if (mem_valid_i) begin
      sel_valid_o = 1'b1;
      sel_code_o  = mem_code_i;
      sel_pc_o    = mem_pc_i;
      sel_value_o = mem_value_i;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/mret sequencer: drain pipeline, commit trap to CSRs, redirect fetch.
// Optional macro TRAP_MTVAL_EN latches and reports the trap value during COMMIT.
module trap_ctrl
  import riscv_pkg::*;
  import tartaruga_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        xcpt_dec_i,
  input  logic        xcpt_exe_i,
  input  logic        xcpt_mem_i,
  input  xcpt_code_t  xcpt_dec_code_i,
  input  xcpt_code_t  xcpt_exe_code_i,
  input  xcpt_code_t  xcpt_mem_code_i,
  input  logic [31:0] xcpt_dec_pc_i,
  input  logic [31:0] xcpt_exe_pc_i,
  input  logic [31:0] xcpt_mem_pc_i,
  input  logic [31:0] xcpt_dec_value_i,
  input  logic [31:0] xcpt_exe_value_i,
  input  logic [31:0] xcpt_mem_value_i,
  input  logic        mret_i,
  input  logic [31:0] mepc_i,
  output logic        xcpt_o,
  output xcpt_code_t  xcpt_code_o,
  output logic [31:0] xcpt_pc_o,
  output logic [31:0] xcpt_value_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        busy_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output trap_state_t dbg_state_o
);

  localparam logic [DRAIN_CNT_W-1:0] CNT_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  trap_state_t            r_state, w_state_nxt;
  logic [DRAIN_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic                   r_mret;
  xcpt_code_t             r_code;
  logic [31:0]            r_pc;
  logic                   w_sel_valid;
  xcpt_code_t             w_sel_code;
  logic [31:0]            w_sel_pc;
  logic [31:0]            w_sel_value;
  logic                   w_accept;

  trap_prio_sel u_prio (
    .dec_valid_i (xcpt_dec_i),
    .dec_code_i  (xcpt_dec_code_i),
    .dec_pc_i    (xcpt_dec_pc_i),
    .dec_value_i (xcpt_dec_value_i),
    .exe_valid_i (xcpt_exe_i),
    .exe_code_i  (xcpt_exe_code_i),
    .exe_pc_i    (xcpt_exe_pc_i),
    .exe_value_i (xcpt_exe_value_i),
    .mem_valid_i (xcpt_mem_i),
    .mem_code_i  (xcpt_mem_code_i),
    .mem_pc_i    (xcpt_mem_pc_i),
    .mem_value_i (xcpt_mem_value_i),
    .sel_valid_o (w_sel_valid),
    .sel_code_o  (w_sel_code),
    .sel_pc_o    (w_sel_pc),
    .sel_value_o (w_sel_value)
  );

  assign w_accept = (r_state == ST_IDLE) && (w_sel_valid || mret_i);

  // r_pc holds the faulting PC for a trap and mepc for an mret.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_mret  <= 1'b0;
      r_code  <= '0;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_mret <= !w_sel_valid;
        r_code <= w_sel_valid ? w_sel_code : '0;
        r_pc   <= w_sel_valid ? w_sel_pc : mepc_i;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      ST_FLUSH: begin
        if (r_cnt == '0) begin
          w_state_nxt = r_mret ? ST_REDIRECT : ST_COMMIT;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_COMMIT:   w_state_nxt = ST_REDIRECT;
      ST_REDIRECT: w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef TRAP_MTVAL_EN
  logic [31:0] r_value;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_value <= '0;
    end else if (w_accept) begin
      r_value <= w_sel_valid ? w_sel_value : '0;
    end
  end

  assign xcpt_value_o = xcpt_o ? r_value : '0;
`else
  logic w_unused_value;
  assign w_unused_value = ^w_sel_value;
  assign xcpt_value_o   = '0;
`endif

  assign xcpt_o           = (r_state == ST_COMMIT);
  assign xcpt_code_o      = xcpt_o ? r_code : '0;
  assign xcpt_pc_o        = xcpt_o ? r_pc : '0;
  assign flush_o          = (r_state == ST_FLUSH);
  assign busy_o           = (r_state != ST_IDLE);
  assign stall_o          = (r_state != ST_IDLE);
  assign redirect_valid_o = (r_state == ST_REDIRECT);
  assign redirect_pc_o    = redirect_valid_o ? (r_mret ? r_pc : TRAP_VECTOR) : '0;
  assign dbg_state_o      = r_state;

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100: fetch redirect target on exception entry.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 2: cycles flush_o is held per trap or mret, legal range 1..15.
REQ-003 SHALL have port clk_i  in  1  clock; all state is updated on its rising edge.
REQ-004 SHALL have port rstn_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports xcpt_dec_i / xcpt_exe_i / xcpt_mem_i  in  1 each  exception raised by decode / execute / memory stage.
REQ-006 SHALL have ports xcpt_dec_code_i / xcpt_exe_code_i / xcpt_mem_code_i  in  5 each  cause code (xcpt_code_t).
REQ-007 SHALL have ports xcpt_dec_pc_i / xcpt_exe_pc_i / xcpt_mem_pc_i  in  32 each  faulting PC.
REQ-008 SHALL have ports xcpt_dec_value_i / xcpt_exe_value_i / xcpt_mem_value_i  in  32 each  trap value.
REQ-009 SHALL have port mret_i  in  1  mret reached commit; port mepc_i  in  32  current mepc from CSR unit.
REQ-010 SHALL have ports xcpt_o  out  1, xcpt_code_o  out  5, xcpt_pc_o  out  32, xcpt_value_o  out  32: one-cycle trap commit to CSR unit.
REQ-011 SHALL have ports flush_o  out  1, stall_o  out  1, busy_o  out  1: pipeline control.
REQ-012 SHALL have ports redirect_valid_o  out  1, redirect_pc_o  out  32: one-cycle fetch redirect.

Function
REQ-013 SHALL implement FSM states IDLE, FLUSH, COMMIT, REDIRECT.
REQ-014 In IDLE, any xcpt_*_i high at cycle T SHALL latch the winning source's code/pc/value and enter FLUSH at T+1; priority mem > exe > dec (oldest instruction wins).
REQ-015 In IDLE, mret_i high with no exception at T SHALL latch mepc_i, set an mret flag and enter FLUSH at T+1; exception wins when both are high.
REQ-016 FLUSH SHALL last exactly DRAIN_CYCLES cycles via down-counter, flush_o=1 throughout; then COMMIT for trap, REDIRECT for mret.
REQ-017 COMMIT SHALL last one cycle with xcpt_o=1 and latched code/pc/value on outputs, then REDIRECT.
REQ-018 REDIRECT SHALL last one cycle with redirect_valid_o=1, redirect_pc_o = TRAP_VECTOR (trap) or latched mepc (mret), then IDLE.
REQ-019 busy_o and stall_o SHALL equal (state != IDLE); combinational from state only.
REQ-020 All xcpt_*_i and mret_i SHALL be ignored outside IDLE; a new event is accepted in the cycle after REDIRECT at the earliest.
REQ-021 xcpt_code_o/xcpt_pc_o/xcpt_value_o SHALL be 0 and redirect_pc_o SHALL be 0 whenever their valid strobe is low.
REQ-022 Trap latency from event at T: xcpt_o at T+DRAIN_CYCLES+1, redirect at T+DRAIN_CYCLES+2; mret redirect at T+DRAIN_CYCLES+1.

Reset
REQ-023 rstn_i low SHALL immediately force IDLE, clear counter, latches and mret flag, and drive every output to 0, including mid-FLUSH/COMMIT/REDIRECT.
REQ-024 After reset release, first event SHALL be accepted on the first rising edge with rstn_i high.

Configuration
REQ-025 Macro TRAP_MTVAL_EN defined: xcpt_value_o carries the latched trap value during COMMIT.
REQ-026 Macro TRAP_MTVAL_EN undefined: value inputs unused, no value latch, xcpt_value_o tied to 0.

Structure
REQ-027 trap_state_t enum and default TRAP_VECTOR constant SHALL live in tartaruga_pkg; xcpt_code_t reused from riscv_pkg.
REQ-028 Priority selection SHALL be a combinational sub-module trap_prio_sel (three sources in, winning valid/code/pc/value out).

Verification
REQ-029 xcpt_mem_i=1, code 5, pc 32'h80, value 32'hDEAD at cycle 0 -> flush_o cycles 1-2, xcpt_o cycle 3 with 5/80/DEAD, redirect 32'h100 cycle 4, busy_o low cycle 5.
REQ-030 xcpt_dec_i (code 2) and xcpt_exe_i (code 4) same cycle -> committed code 4, exe pc.
REQ-031 mret_i=1, mepc_i=32'h200 at cycle 0 -> flush cycles 1-2, no xcpt_o, redirect 32'h200 cycle 3.
REQ-032 mret_i and xcpt_dec_i (code 2) same cycle -> trap path, code 2, redirect 32'h100; xcpt_mem_i pulsed during FLUSH -> ignored.
REQ-033 rstn_i low during COMMIT cycle -> all outputs 0 immediately, IDLE; new xcpt after release follows REQ-029 timing.
REQ-034 Build without TRAP_MTVAL_EN, rerun REQ-029 -> xcpt_value_o stays 0.
